// File: rtl/lsu_align_ctrl.sv
// lsu_align_ctrl: load/store sequencer that aligns memory requests and extends loaded data.
// Revision 1.0 - initial release.
`default_nettype none

module lsu_align_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_write,
  output logic [31:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [1:0]  out_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0]       C_SZ_B     = 2'd0;
  localparam logic [1:0]       C_SZ_H     = 2'd1;
  localparam logic [1:0]       C_SZ_W     = 2'd2;
  localparam logic [1:0]       C_ERR_OK   = 2'b00;
  localparam logic [1:0]       C_ERR_MIS  = 2'b01;
  localparam logic [1:0]       C_ERR_TO   = 2'b10;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_lane;
  logic [2:0]       r_funct3;
  logic             r_write;

  logic [1:0]  w_size;
  logic        w_misaligned;
  logic [3:0]  w_mask4;
  logic [31:0] w_wdata_sh;
  logic [1:0]  w_rsize;
  logic [31:0] w_lane_word;
  logic [31:0] w_load_ext;

  assign in_ready = (r_state == S_IDLE);

  // funct3[1:0] selects size; 1x (including the undefined codes) is a word.
  assign w_size = in_funct3[1] ? C_SZ_W : {1'b0, in_funct3[0]};

  assign w_misaligned = ((w_size == C_SZ_H) && in_addr[0]) ||
                        ((w_size == C_SZ_W) && (in_addr[1:0] != 2'b00));

  always_comb begin
    w_mask4 = 4'b1111;
    case (w_size)
      C_SZ_B:  w_mask4 = 4'b0001 << in_addr[1:0];
      C_SZ_H:  w_mask4 = 4'b0011 << in_addr[1:0];
      default: w_mask4 = 4'b1111;
    endcase
  end

  assign w_wdata_sh = in_wdata << {in_addr[1:0], 3'b000};

  assign w_rsize     = r_funct3[1] ? C_SZ_W : {1'b0, r_funct3[0]};
  assign w_lane_word = mem_resp_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_load_ext = w_lane_word;
    case (w_rsize)
      C_SZ_B:  w_load_ext = r_funct3[2] ? {24'd0, w_lane_word[7:0]}
                                        : {{24{w_lane_word[7]}}, w_lane_word[7:0]};
      C_SZ_H:  w_load_ext = r_funct3[2] ? {16'd0, w_lane_word[15:0]}
                                        : {{16{w_lane_word[15]}}, w_lane_word[15:0]};
      default: w_load_ext = w_lane_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_lane        <= 2'b00;
      r_funct3      <= 3'b000;
      r_write       <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= 32'd0;
      mem_req_write <= 1'b0;
      mem_req_wdata <= 32'd0;
      mem_req_wmask <= 8'd0;
      out_valid     <= 1'b0;
      out_result    <= 32'd0;
      out_err       <= C_ERR_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_lane   <= in_addr[1:0];
            r_funct3 <= in_funct3;
            r_write  <= in_mem_write;
            if (w_misaligned) begin
              r_state    <= S_RESP;
              out_valid  <= 1'b1;
              out_result <= 32'd0;
              out_err    <= C_ERR_MIS;
            end else if (!in_mem_read && !in_mem_write) begin
              r_state    <= S_RESP;
              out_valid  <= 1'b1;
              out_result <= 32'd0;
              out_err    <= C_ERR_OK;
            end else begin
              // Loads present a zero mask and zero data on the bus.
              r_state       <= S_REQ;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {in_addr[31:2], 2'b00};
              mem_req_write <= in_mem_write;
              mem_req_wdata <= in_mem_write ? w_wdata_sh : 32'd0;
              mem_req_wmask <= in_mem_write ? {4'b0000, w_mask4} : 8'd0;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            r_state       <= S_WAIT;
            mem_req_valid <= 1'b0;
            r_cnt         <= '0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // A response in the final counted cycle still beats the timeout.
          if (mem_resp_valid) begin
            r_state    <= S_RESP;
            out_valid  <= 1'b1;
            out_result <= r_write ? 32'd0 : w_load_ext;
            out_err    <= C_ERR_OK;
          end else if (r_cnt == C_CNT_LAST) begin
            r_state    <= S_RESP;
            out_valid  <= 1'b1;
            out_result <= 32'd0;
            out_err    <= C_ERR_TO;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_align_ctrl.sv
// tb_lsu_align_ctrl: directed scoreboard bench for lsu_align_ctrl.
`default_nettype none

module tb_lsu_align_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = 32'd0;
  logic [31:0] in_wdata = 32'd0;
  logic        in_mem_read = 1'b0;
  logic        in_mem_write = 1'b0;
  logic [2:0]  in_funct3 = 3'd0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_req_write;
  logic [31:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [1:0]  out_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  lsu_align_ctrl #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_funct3(in_funct3),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_write(mem_req_write), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_err(out_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, " req_write"}, 32'(mem_req_write), 32'd0);
    chk({tag, " req_addr"}, mem_req_addr, 32'd0);
    chk({tag, " req_wdata"}, mem_req_wdata, 32'd0);
    chk({tag, " req_wmask"}, 32'(mem_req_wmask), 32'd0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_result"}, out_result, 32'd0);
    chk({tag, " out_err"}, 32'(out_err), 32'd0);
  endtask

  // Drives one operation at a negedge and pushes the expected result.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic rd,
                       input logic wr, input logic [2:0] f3,
                       input logic [31:0] eres, input logic [1:0] eerr, input bit push);
    exp_t e;
    chk("in_ready before issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_addr = addr; in_wdata = wdata;
    in_mem_read = rd; in_mem_write = wr; in_funct3 = f3;
    e.res = eres; e.err = eerr;
    if (push) sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // addr/wdata/rd/wr/f3: operation; rdata/resp_delay (-1 = never): memory model;
  // req_stall/out_stall: back-pressure; exp_lat: cycles from WAIT entry (or accept) to out_valid.
  task automatic run_op(input string tag,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic rd,
                        input logic wr, input logic [2:0] f3,
                        input logic [31:0] rdata, input int resp_delay,
                        input int req_stall, input int out_stall,
                        input logic [31:0] eres, input logic [1:0] eerr,
                        input bit emem, input logic [31:0] emaddr, input logic [7:0] emask,
                        input logic [31:0] ewdata, input int exp_lat);
    int lat;
    exp_t e;
    lat = 0;
    issue(addr, wdata, rd, wr, f3, eres, eerr, 1'b1);
    if (emem) begin
      chk({tag, " req_valid"}, 32'(mem_req_valid), 32'd1);
      chk({tag, " req_addr"}, mem_req_addr, emaddr);
      chk({tag, " req_write"}, 32'(mem_req_write), 32'(wr));
      chk({tag, " req_wmask"}, 32'(mem_req_wmask), 32'(emask));
      if (wr) chk({tag, " req_wdata"}, mem_req_wdata, ewdata);
      for (int i = 0; i < req_stall; i++) begin
        @(negedge clk);
        chk({tag, " stall valid"}, 32'(mem_req_valid), 32'd1);
        chk({tag, " stall addr"}, mem_req_addr, emaddr);
        chk({tag, " stall wmask"}, 32'(mem_req_wmask), 32'(emask));
        if (wr) chk({tag, " stall wdata"}, mem_req_wdata, ewdata);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk({tag, " req dropped"}, 32'(mem_req_valid), 32'd0);
      if (resp_delay >= 0) begin
        for (int i = 0; i < resp_delay; i++) begin
          @(negedge clk);
          lat++;
        end
        mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
        @(negedge clk);
        lat++;
        mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0;
      end
    end else begin
      chk({tag, " no req"}, 32'(mem_req_valid), 32'd0);
    end
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    if (exp_lat >= 0) chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    for (int i = 0; i < out_stall; i++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold result"}, out_result, eres);
    end
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, " result"}, out_result, e.res);
      chk({tag, " err"}, 32'(out_err), 32'(e.err));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " back to idle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("after reset release");

    run_op("LB", 32'h8000_0003, 32'h0, 1, 0, 3'b000, 32'h80AB_CDEF, 0, 0, 0,
           32'hFFFF_FF80, 2'b00, 1, 32'h8000_0000, 8'h00, 32'h0, 1);
    run_op("LHU", 32'h8000_0002, 32'h0, 1, 0, 3'b101, 32'hBEEF_1234, 0, 0, 0,
           32'h0000_BEEF, 2'b00, 1, 32'h8000_0000, 8'h00, 32'h0, 1);
    run_op("LH", 32'h8000_0002, 32'h0, 1, 0, 3'b001, 32'hBEEF_1234, 2, 0, 0,
           32'hFFFF_BEEF, 2'b00, 1, 32'h8000_0000, 8'h00, 32'h0, 3);
    run_op("SH", 32'h8000_0002, 32'h0000_A5A5, 0, 1, 3'b001, 32'hFFFF_FFFF, 0, 5, 3,
           32'h0, 2'b00, 1, 32'h8000_0000, 8'h0C, 32'hA5A5_0000, 1);
    run_op("LW misaligned", 32'h8000_0001, 32'h0, 1, 0, 3'b010, 32'h0, -1, 0, 0,
           32'h0, 2'b01, 0, 32'h0, 8'h00, 32'h0, 0);
    run_op("SB", 32'h1000_0001, 32'h0000_00C3, 0, 1, 3'b000, 32'h0, 1, 0, 0,
           32'h0, 2'b00, 1, 32'h1000_0000, 8'h02, 32'h0000_C300, 2);
    run_op("SW", 32'h1000_0004, 32'h1234_5678, 0, 1, 3'b010, 32'h0, 0, 1, 0,
           32'h0, 2'b00, 1, 32'h1000_0004, 8'h0F, 32'h1234_5678, 1);
    run_op("LBU", 32'h1000_0001, 32'h0, 1, 0, 3'b100, 32'h1122_F344, 0, 0, 1,
           32'h0000_00F3, 2'b00, 1, 32'h1000_0000, 8'h00, 32'h0, 1);
    run_op("LW", 32'h0000_0020, 32'h0, 1, 0, 3'b010, 32'hDEAD_BEEF, 0, 0, 0,
           32'hDEAD_BEEF, 2'b00, 1, 32'h0000_0020, 8'h00, 32'h0, 1);
    run_op("RW write wins", 32'h0000_0024, 32'hCAFE_F00D, 1, 1, 3'b010, 32'h5555_5555, 0, 0, 0,
           32'h0, 2'b00, 1, 32'h0000_0024, 8'h0F, 32'hCAFE_F00D, 1);
    run_op("noop", 32'h0000_0030, 32'h0, 0, 0, 3'b010, 32'h0, -1, 0, 0,
           32'h0, 2'b00, 0, 32'h0, 8'h00, 32'h0, 0);
    run_op("f3 111 as W", 32'h0000_0002, 32'h0, 1, 0, 3'b111, 32'h0, -1, 0, 0,
           32'h0, 2'b01, 0, 32'h0, 8'h00, 32'h0, 0);
    run_op("timeout", 32'h0000_0040, 32'h0, 1, 0, 3'b010, 32'h0, -1, 0, 0,
           32'h0, 2'b10, 1, 32'h0000_0040, 8'h00, 32'h0, 64);
    run_op("resp in last cycle", 32'h0000_0044, 32'h0, 1, 0, 3'b010, 32'h0BAD_F00D, 63, 0, 0,
           32'h0BAD_F00D, 2'b00, 1, 32'h0000_0044, 8'h00, 32'h0, 64);

    // Reset pulsed while the second operation of a pair is waiting on memory.
    run_op("pre-reset SH", 32'h8000_0002, 32'h0000_A5A5, 0, 1, 3'b001, 32'h0, 0, 5, 3,
           32'h0, 2'b00, 1, 32'h8000_0000, 8'h0C, 32'hA5A5_0000, 1);
    issue(32'h0000_0050, 32'h0, 1'b1, 1'b0, 3'b010, 32'h0, 2'b00, 1'b0);
    chk("rst op req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst op still waiting", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post reset");
    run_op("LBU after reset", 32'h1000_0001, 32'h0, 1, 0, 3'b100, 32'h1122_F344, 0, 0, 0,
           32'h0000_00F3, 2'b00, 1, 32'h1000_0000, 8'h00, 32'h0, 1);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
